// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour packing and small helpers for the
// 640x480@60 Hz timing generator and its axis counters.
package vga_pkg;

  // Counter and colour widths
  localparam int COUNT_W = 10;
  localparam int RGB_W   = 6;

  // Default 640x480@60 Hz horizontal timing (clocks)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  // Default vertical timing (lines)
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync windows are [start, end)
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // Standard 640x480 uses active-low sync
  localparam logic SYNC_POL_DEF = 1'b0;

  // Colour word {R1,R0,G1,G0,B1,B0} as packed onto the PMOD pins
  localparam logic [RGB_W-1:0] RGB_BLACK = '0;
  localparam int R_LSB = 4;
  localparam int G_LSB = 2;
  localparam int B_LSB = 0;

  // Pin level for a sync output given whether the counter is inside its pulse
  function automatic logic sync_level(input logic in_sync, input logic pol);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: a wrapping counter with active-area and
// sync-window decode. Used once per line (always enabled) and once per
// frame (enabled by the line wrap).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int SYNC_START = H_SYNC_START,
  parameter int SYNC_END   = H_SYNC_END,
  parameter int ACTIVE     = H_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               in_sync
);

  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACT_END = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] SYNC_LO = COUNT_W'(SYNC_START);
  localparam logic [COUNT_W-1:0] SYNC_HI = COUNT_W'(SYNC_END);

  logic [COUNT_W-1:0] count_q, count_d;

  // Next count: advance when enabled, return to zero after the last position
  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Counter register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign active  = (count_q < ACT_END);
  assign in_sync = (count_q >= SYNC_LO) && (count_q < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: drives x/y/next_frame to the pattern
// generators and registers their colour together with hsync/vsync so all
// pin-bound outputs leave on the same clock edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [COUNT_W-1:0] x,
  output logic [COUNT_W-1:0] y,
  output logic               next_frame,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam int LINE_CLKS   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  logic h_wrap, h_active, h_in_sync;
  logic v_wrap, v_active, v_in_sync;

  vga_axis_counter #(
    .TOTAL      (LINE_CLKS),
    .SYNC_START (H_ACTIVE + H_FRONT),
    .SYNC_END   (H_ACTIVE + H_FRONT + H_SYNC),
    .ACTIVE     (H_ACTIVE)
  ) u_h_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .count   (x),
    .wrap    (h_wrap),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  vga_axis_counter #(
    .TOTAL      (FRAME_LINES),
    .SYNC_START (V_ACTIVE + V_FRONT),
    .SYNC_END   (V_ACTIVE + V_FRONT + V_SYNC),
    .ACTIVE     (V_ACTIVE)
  ) u_v_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (h_wrap),
    .count   (y),
    .wrap    (v_wrap),
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  // The vertical wrap fires only on the last clock of the last line, which
  // is exactly the frame boundary the pattern generators step on.
  assign next_frame = v_wrap;
  assign display_on = h_active && v_active;

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  // Output stage inputs: blank colour outside the visible area, map sync windows to pin level
  always_comb begin
    rgb_d   = display_on ? rgb_in : RGB_BLACK;
    hsync_d = sync_level(h_in_sync, SYNC_POL);
    vsync_d = sync_level(v_in_sync, SYNC_POL);
  end

  // Single output register so colour and both syncs change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= RGB_BLACK;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign rgb_out = rgb_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for line timing and
// colour alignment, and a shrunken active-high-sync instance for whole-frame
// behaviour. A per-cycle scoreboard predicts every output from a cycle count.
module tb_vga_timing_gen;

  typedef struct {
    int   ha, hf, hs, hb, va, vf, vs, vb;
    logic pol;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       nf;
  } pos_t;

  typedef struct packed {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } out_t;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       nf;
    logic [5:0] rgb;
    logic       hs;
  } vec_t;

  cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  cfg_t cfg_s = '{16, 2, 4, 3, 8, 1, 2, 3, 1'b1};
  localparam int FRAME_S = 25 * 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d = 1'b1, rst_s = 1'b1;
  logic [5:0] rgb_in_d = '0, rgb_in_s = '0;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic       nf_d, de_d, hs_d, vs_d, nf_s, de_s, hs_s, vs_s;
  logic [5:0] rgb_out_d, rgb_out_s;

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst_d), .rgb_in(rgb_in_d), .x(x_d), .y(y_d),
    .next_frame(nf_d), .display_on(de_d), .hsync(hs_d), .vsync(vs_d),
    .rgb_out(rgb_out_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .rgb_in(rgb_in_s), .x(x_s), .y(y_s),
    .next_frame(nf_s), .display_on(de_s), .hsync(hs_s), .vsync(vs_s),
    .rgb_out(rgb_out_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Raster position after cnt clocks since reset release
  function automatic pos_t model_pos(input cfg_t c, input int cnt);
    int ht, vt, px, py;
    pos_t p;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    px = cnt % ht;
    py = (cnt / ht) % vt;
    p.x  = 10'(px);
    p.y  = 10'(py);
    p.de = (px < c.ha) && (py < c.va);
    p.nf = (px == ht - 1) && (py == vt - 1);
    return p;
  endfunction

  // Registered outputs expected one clock after position cnt with colour rgb
  function automatic out_t model_out(input cfg_t c, input int cnt, input logic [5:0] rgb);
    int ht, vt, px, py;
    out_t o;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    px = cnt % ht;
    py = (cnt / ht) % vt;
    o.rgb = ((px < c.ha) && (py < c.va)) ? rgb : 6'd0;
    o.hs  = ((px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hs)) ? c.pol : ~c.pol;
    o.vs  = ((py >= c.va + c.vf) && (py < c.va + c.vf + c.vs)) ? c.pol : ~c.pol;
    return o;
  endfunction

  // Scoreboard, default instance: colour is x[5:0] so alignment is visible
  out_t q_d[$];
  int   cnt_d = 0;
  always @(negedge clk) begin
    pos_t ep;
    out_t eo, rst_o;
    rst_o = '{6'd0, ~cfg_d.pol, ~cfg_d.pol};
    if (rst_d) begin
      ep = model_pos(cfg_d, 0);
      chk("d_rst_pos", 32'({x_d, y_d, de_d, nf_d}), 32'(ep));
      chk("d_rst_out", 32'({rgb_out_d, hs_d, vs_d}), 32'(rst_o));
      cnt_d = 0;
      q_d.delete();
      q_d.push_back(rst_o);
      rgb_in_d = 6'($urandom);
    end else begin
      ep = model_pos(cfg_d, cnt_d);
      chk("d_pos", 32'({x_d, y_d, de_d, nf_d}), 32'(ep));
      if (q_d.size() == 0) begin
        chk("d_queue_empty", 32'(0), 32'(1));
      end else begin
        eo = q_d.pop_front();
        chk("d_out", 32'({rgb_out_d, hs_d, vs_d}), 32'(eo));
      end
      rgb_in_d = ep.x[5:0];
      q_d.push_back(model_out(cfg_d, cnt_d, rgb_in_d));
      cnt_d++;
    end
  end

  // Scoreboard, small instance: white for the first frame, random afterwards
  out_t q_s[$];
  int   cnt_s = 0;
  always @(negedge clk) begin
    pos_t ep;
    out_t eo, rst_o;
    rst_o = '{6'd0, ~cfg_s.pol, ~cfg_s.pol};
    if (rst_s) begin
      ep = model_pos(cfg_s, 0);
      chk("s_rst_pos", 32'({x_s, y_s, de_s, nf_s}), 32'(ep));
      chk("s_rst_out", 32'({rgb_out_s, hs_s, vs_s}), 32'(rst_o));
      cnt_s = 0;
      q_s.delete();
      q_s.push_back(rst_o);
      rgb_in_s = 6'h3F;
    end else begin
      ep = model_pos(cfg_s, cnt_s);
      chk("s_pos", 32'({x_s, y_s, de_s, nf_s}), 32'(ep));
      if (q_s.size() == 0) begin
        chk("s_queue_empty", 32'(0), 32'(1));
      end else begin
        eo = q_s.pop_front();
        chk("s_out", 32'({rgb_out_s, hs_s, vs_s}), 32'(eo));
      end
      rgb_in_s = (cnt_s < FRAME_S) ? 6'h3F : 6'($urandom);
      q_s.push_back(model_out(cfg_s, cnt_s, rgb_in_s));
      cnt_s++;
    end
  end

  // Default instance: checkpoint table, mid-line reset, then one full line measured
  task automatic run_default();
    vec_t tbl[17];
    int   n, low, first;
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[1]  = '{1,    10'd1,   10'd0, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[2]  = '{2,    10'd2,   10'd0, 1'b1, 1'b0, 6'h01, 1'b1};
    tbl[3]  = '{100,  10'd100, 10'd0, 1'b1, 1'b0, 6'h23, 1'b1};
    tbl[4]  = '{639,  10'd639, 10'd0, 1'b1, 1'b0, 6'h3E, 1'b1};
    tbl[5]  = '{640,  10'd640, 10'd0, 1'b0, 1'b0, 6'h3F, 1'b1};
    tbl[6]  = '{641,  10'd641, 10'd0, 1'b0, 1'b0, 6'h00, 1'b1};
    tbl[7]  = '{656,  10'd656, 10'd0, 1'b0, 1'b0, 6'h00, 1'b1};
    tbl[8]  = '{657,  10'd657, 10'd0, 1'b0, 1'b0, 6'h00, 1'b0};
    tbl[9]  = '{751,  10'd751, 10'd0, 1'b0, 1'b0, 6'h00, 1'b0};
    tbl[10] = '{752,  10'd752, 10'd0, 1'b0, 1'b0, 6'h00, 1'b0};
    tbl[11] = '{753,  10'd753, 10'd0, 1'b0, 1'b0, 6'h00, 1'b1};
    tbl[12] = '{799,  10'd799, 10'd0, 1'b0, 1'b0, 6'h00, 1'b1};
    tbl[13] = '{800,  10'd0,   10'd1, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[14] = '{801,  10'd1,   10'd1, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[15] = '{900,  10'd100, 10'd1, 1'b1, 1'b0, 6'h23, 1'b1};
    tbl[16] = '{1457, 10'd657, 10'd1, 1'b0, 1'b0, 6'h00, 1'b0};

    repeat (3) @(posedge clk);
    #2 rst_d = 1'b0;
    #1;
    n = 0;
    foreach (tbl[i]) begin
      while (n < tbl[i].cyc) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("tbl%0d_pos", i), 32'({x_d, y_d, de_d, nf_d}),
          32'({tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].nf}));
      chk($sformatf("tbl%0d_out", i), 32'({rgb_out_d, hs_d, vs_d}),
          32'({tbl[i].rgb, tbl[i].hs, 1'b1}));
    end

    // Advance into the hsync pulse of line 1, then reset asynchronously
    while (n < 1500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_rst_hsync", 32'(hs_d), 32'(0));
    rst_d = 1'b1;
    #1;
    chk("rst_now_pos", 32'({x_d, y_d, nf_d}), 32'(0));
    chk("rst_now_out", 32'({rgb_out_d, hs_d, vs_d}), 32'({6'h00, 1'b1, 1'b1}));
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hold_out", 32'({rgb_out_d, hs_d, vs_d, nf_d}), 32'({6'h00, 1'b1, 1'b1, 1'b0}));
    rst_d = 1'b0;
    #1;
    chk("rst_rel_pos", 32'({x_d, y_d, nf_d}), 32'(0));

    // One full line after release: hsync width and first low sample
    low   = 0;
    first = -1;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk);
      #1;
      if (hs_d == 1'b0) begin
        low++;
        if (first < 0) first = k;
      end
    end
    chk("line_wrap_xy", 32'({x_d, y_d}), 32'({10'd0, 10'd1}));
    chk("hsync_width", 32'(low), 32'(96));
    chk("hsync_first", 32'(first), 32'(657));
  endtask

  // Small instance: three whole frames, counting frame pulses and vsync
  task automatic run_small();
    int nf_cnt, vs_cnt, vs_first, white_cnt;
    repeat (4) @(posedge clk);
    #2 rst_s = 1'b0;
    #1;
    nf_cnt    = 0;
    vs_cnt    = 0;
    vs_first  = -1;
    white_cnt = 0;
    for (int k = 1; k <= 3 * FRAME_S; k++) begin
      @(posedge clk);
      #1;
      if (nf_s) nf_cnt++;
      if (vs_s == 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
      end
      if (k <= FRAME_S && rgb_out_s == 6'h3F) white_cnt++;
    end
    chk("frame_pulses", 32'(nf_cnt), 32'(3));
    chk("vsync_cycles", 32'(vs_cnt), 32'(150));
    chk("vsync_first", 32'(vs_first), 32'(226));
    chk("white_pixels", 32'(white_cnt), 32'(128));
  endtask

  initial begin
    fork
      run_default();
      run_small();
    join
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
